// File: rtl/rx_serial_pkg.sv
// -----------------------------------------------------------------------------
// rx_serial_pkg
// Shared definitions for the 7O1 serial receiver:
//   - 4-bit FSM state codes (also visible on db_estado)
//   - default baud divider (50 MHz / 115200)
//   - ASCII constant for the '#' terminator character
//   - odd-parity check helper
// -----------------------------------------------------------------------------
package rx_serial_pkg;

  localparam int BAUD_DIV_DEFAULT = 434;

  localparam logic [6:0] ASCII_HASHTAG = 7'h23;

  localparam logic [3:0] EST_REPOUSO      = 4'd0;
  localparam logic [3:0] EST_INICIO       = 4'd1;
  localparam logic [3:0] EST_DADOS        = 4'd2;
  localparam logic [3:0] EST_PARIDADE     = 4'd3;
  localparam logic [3:0] EST_PARADA       = 4'd4;
  localparam logic [3:0] EST_ARMAZENA     = 4'd5;
  localparam logic [3:0] EST_ESPERA_LINHA = 4'd6;

  typedef enum logic [3:0] {
    REPOUSO      = EST_REPOUSO,
    INICIO       = EST_INICIO,
    DADOS        = EST_DADOS,
    PARIDADE     = EST_PARIDADE,
    PARADA       = EST_PARADA,
    ARMAZENA     = EST_ARMAZENA,
    ESPERA_LINHA = EST_ESPERA_LINHA
  } estado_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic paridade_impar_ok(input logic [6:0] dados, input logic paridade);
    return ^{dados, paridade};
  endfunction

endpackage

// File: rtl/rx_serial_7o1_contador_baud.sv
// -----------------------------------------------------------------------------
// contador_baud
// Modulo-M counter (0..M-1) with synchronous clear.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-low reset
//   limpa  in   synchronous clear (count returns to 0 next cycle)
//   fim    out  count == M-1   (full bit period elapsed)
//   meio   out  count == M/2-1 (half bit period elapsed)
// -----------------------------------------------------------------------------
module contador_baud #(
  parameter int M = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  output logic fim,
  output logic meio
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  logic [CW-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (limpa || fim) begin
      contagem <= '0;
    end else begin
      contagem <= contagem + 1'b1;
    end
  end

  assign fim  = (contagem == CW'(M - 1));
  assign meio = (contagem == CW'(M / 2 - 1));

endmodule

// File: rtl/rx_serial_7o1.sv
// -----------------------------------------------------------------------------
// rx_serial_7o1
// Receiver for the 7O1 asynchronous format: start, 7 data bits LSB first,
// odd parity, stop. Rebuilds each character and flags parity/framing errors.
// Parameter:
//   BAUD_DIV  clock cycles per bit; must be >= 4 and even
// Ports:
//   clock           in   system clock
//   reset           in   asynchronous active-low reset
//   entrada_serial  in   serial line, idles high, asynchronous to clock
//   dados_ascii     out  last received character
//   pronto          out  one-cycle pulse, new character stored
//   paridade_ok     out  odd parity of last frame correct
//   erro_parada     out  stop bit of last frame sampled 0
//   db_estado       out  current FSM state code
// -----------------------------------------------------------------------------
module rx_serial_7o1
  import rx_serial_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       paridade_ok,
  output logic       erro_parada,
  output logic [3:0] db_estado
);

  // Two-flop synchronizer; resets to the idle (high) line level so reset
  // release never looks like a start bit.
  logic sync_a;
  logic s_rx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a <= 1'b1;
      s_rx   <= 1'b1;
    end else begin
      sync_a <= entrada_serial;
      s_rx   <= sync_a;
    end
  end

  estado_t estado;
  estado_t estado_prox;

  logic       fim;
  logic       meio;
  logic       limpa;
  logic       desloca;
  logic       amostra_par;
  logic       armazena;
  logic [2:0] indice;
  logic [6:0] registro;
  logic       bit_par;

  // The baud counter restarts on every state change, so each state measures
  // its own interval from its entry cycle.
  assign limpa = (estado_prox != estado);

  contador_baud #(
    .M(BAUD_DIV)
  ) u_contador_baud (
    .clock (clock),
    .reset (reset),
    .limpa (limpa),
    .fim   (fim),
    .meio  (meio)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= REPOUSO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    desloca     = 1'b0;
    amostra_par = 1'b0;
    armazena    = 1'b0;
    case (estado)
      REPOUSO: begin
        if (!s_rx) estado_prox = INICIO;
      end
      INICIO: begin
        // Mid-start-bit check: a line already back high was a glitch.
        if (meio) estado_prox = s_rx ? REPOUSO : DADOS;
      end
      DADOS: begin
        if (fim) begin
          desloca = 1'b1;
          if (indice == 3'd6) estado_prox = PARIDADE;
        end
      end
      PARIDADE: begin
        if (fim) begin
          amostra_par = 1'b1;
          estado_prox = PARADA;
        end
      end
      PARADA: begin
        // Stop-bit sample: results are latched on this edge so they are
        // already valid during the ARMAZENA cycle that raises pronto.
        if (fim) begin
          armazena    = 1'b1;
          estado_prox = ARMAZENA;
        end
      end
      ARMAZENA: begin
        estado_prox = s_rx ? REPOUSO : ESPERA_LINHA;
      end
      ESPERA_LINHA: begin
        // A line held low after a frame must not be taken as a new start bit.
        if (s_rx) estado_prox = REPOUSO;
      end
      default: begin
        estado_prox = REPOUSO;
      end
    endcase
  end

  // Data path: LSB arrives first, so shift right and insert at the MSB.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice   <= '0;
      registro <= '0;
      bit_par  <= 1'b0;
    end else begin
      if (estado != DADOS) begin
        indice <= '0;
      end else if (desloca) begin
        indice <= indice + 3'd1;
      end
      if (desloca) registro <= {s_rx, registro[6:1]};
      if (amostra_par) bit_par <= s_rx;
    end
  end

  // Output registers change only when a complete frame is stored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados_ascii <= '0;
      paridade_ok <= 1'b0;
      erro_parada <= 1'b0;
    end else if (armazena) begin
      dados_ascii <= registro;
      paridade_ok <= paridade_impar_ok(registro, bit_par);
      erro_parada <= ~s_rx;
    end
  end

  assign pronto    = (estado == ARMAZENA);
  assign db_estado = estado;

endmodule

// File: doc/rx_serial_7o1.md
# rx_serial_7o1

Serial receiver for the 7O1 asynchronous format: 1 start bit, 7 data bits LSB first, 1 odd-parity bit, 1 stop bit. It sits directly downstream of the ASCII serial transmitter and consumes its `saida_serial` line. It rebuilds each character ('0'..'9', '#') and flags parity and framing errors, so the measurement stream can be checked on-board and looped back in simulation.

## Interface
- `BAUD_DIV`, default 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 4 and even.
- `clock`  in  1  system clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset; 0 forces reset state immediately
- `entrada_serial`  in  1  serial line; idles high; asynchronous to `clock`
- `dados_ascii`  out  7  last received character
- `pronto`  out  1  one-cycle pulse: new character stored
- `paridade_ok`  out  1  odd parity of last frame correct
- `erro_parada`  out  1  stop bit of last frame sampled 0
- `db_estado`  out  4  current FSM state code (debug)

## Operation
- `entrada_serial` passes through a 2-flop synchronizer. All decisions use the synchronized value `s_rx`.
- The baud counter counts 0..BAUD_DIV-1 and cleared on every state entry. "Tick" means count == BAUD_DIV-1. "Half tick" means count == BAUD_DIV/2-1.
- FSM states and codes:
  - REPOUSO (0): waits for `s_rx` = 0, then goes to INICIO.
  - INICIO (1): on half tick, if `s_rx` = 1 it is a glitch, return to REPOUSO, nothing stored. Otherwise go to DADOS with bit index 0.
  - DADOS (2): on each tick, shift `s_rx` into a 7-bit register LSB first and increment the index. After the 7th sample go to PARIDADE.
  - PARIDADE (3): on tick, sample the parity bit, then go to PARADA.
  - PARADA (4): on tick, sample the stop bit, then go to ARMAZENA.
  - ARMAZENA (5): one cycle. Updates `dados_ascii`, `paridade_ok` and `erro_parada` together and asserts `pronto`. Goes to REPOUSO if `s_rx` = 1, else to ESPERA_LINHA.
  - ESPERA_LINHA (6): waits for `s_rx` = 1, then goes to REPOUSO. Prevents a held-low line from re-triggering.
- `paridade_ok` = XOR of the 7 data bits and the parity bit equals 1.
- A frame with a parity or stop error is still stored and signalled with `pronto`. The flags describe that frame.
- Outputs hold their values between frames. No output changes on glitch rejection.

## Timing
- Reset values: `dados_ascii` = 0, `pronto` = 0, `paridade_ok` = 0, `erro_parada` = 0, `db_estado` = 0. Synchronizer flops reset to 1.
- Sampling points relative to start edge detection: data bit k is sampled BAUD_DIV/2 + (k+1)·BAUD_DIV cycles after REPOUSO sees `s_rx` = 0. Parity is sampled at +8·BAUD_DIV, stop at +9·BAUD_DIV.
- `pronto` goes high the cycle after the stop sample, for exactly one cycle. Data and flags are valid from that same cycle.
- Line-to-detection latency is 2 cycles (synchronizer), plus 1 cycle for the REPOUSO→INICIO transition.
- Back-to-back frames: a new start bit arriving immediately after the stop bit is accepted with no lost frame.
- Reset asserted mid-frame aborts the frame. The partial character is never stored and `pronto` does not pulse.

## Structure
- Shared package `rx_serial_pkg`:
  - state codes (4-bit localparams, values above)
  - `BAUD_DIV_DEFAULT` = 434
  - ASCII constant `ASCII_HASHTAG` = 7'h23
- One sub-module: `contador_baud`, a parameterized modulo-M counter with synchronous clear and outputs `fim` (tick) and `meio` (half tick).
- The FSM, synchronizer and shift register live in the top module.

## Test plan
All scenarios use BAUD_DIV = 8.
- Send '#': data 0100011, parity 0, stop 1 → one `pronto` pulse, `dados_ascii` = 0x23, `paridade_ok` = 1, `erro_parada` = 0.
- Send '5': 0x35, parity 1 → `dados_ascii` = 0x35, `paridade_ok` = 1. Repeat with parity 0 → `paridade_ok` = 0, `pronto` still pulses.
- Glitch: line low for 3 cycles, then high → no `pronto`, `db_estado` returns to 0, outputs unchanged.
- Framing: send 0x31 with stop = 0 and hold the line low for 20 cycles → `erro_parada` = 1, FSM stays in state 6 with no second `pronto`. Release the line and send 0x32 → received correctly with `erro_parada` = 0.
- Back-to-back: send '1','2','3','#' with no idle gap → four `pronto` pulses, 10·BAUD_DIV apart, in order 0x31, 0x32, 0x33, 0x23.
- Assert `reset` = 0 during data bit 3 of a frame → all outputs 0 immediately. Release, then send 0x30 → `dados_ascii` = 0x30 with `paridade_ok` = 1.
